// File: rtl/mux_key_stream.sv
// mux_key_stream: registered N-channel stream selector (KEY / round-robin).
// clk,rst_n | mode,sel | in_data,in_valid,in_ready | out_* + out_ready.
module mux_key_stream #(
  parameter int                NR_CH       = 4,
  parameter int                SEL_W       = 2,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] DEFAULT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NR_CH*DATA_W-1:0] in_data,
  input  logic [NR_CH-1:0]        in_valid,
  output logic [NR_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_hit,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [SEL_W:0] NR_CH_V =
    (SEL_W+1)'(NR_CH);
  localparam logic [SEL_W-1:0] LAST_CH =
    SEL_W'(NR_CH - 1);

  logic              load;
  logic              key_ok;
  logic              grant_valid;
  logic              dflt_beat;
  logic              xfer;
  logic [SEL_W-1:0]  grant_idx;
  logic [SEL_W-1:0]  rr_next;
  logic [SEL_W-1:0]  rr_ptr;
  logic [DATA_W-1:0] grant_data;

  assign load   = ~out_valid | out_ready;
  assign key_ok = {1'b0, sel} < NR_CH_V;
  assign xfer   = rst_n & load & grant_valid;

  // Grant select. In RR mode the search runs
  // from the highest offset down so the
  // smallest offset from rr_ptr wins.
  always_comb begin
    int c;
    grant_valid = 1'b0;
    grant_idx   = '0;
    dflt_beat   = 1'b0;
    c           = 0;
    if (!mode) begin
      dflt_beat = ~key_ok;
      for (int i = 0; i < NR_CH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
    end else begin
      for (int k = NR_CH - 1; k >= 0; k--) begin
        c = int'(rr_ptr) + k;
        if (c >= NR_CH) c = c - NR_CH;
        if (in_valid[c]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(c);
        end
      end
    end
  end

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < NR_CH; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        in_ready[i] = xfer;
        grant_data  = in_data[DATA_W*i +: DATA_W];
      end
    end
  end

  // Pointer wraps at NR_CH, not 2**SEL_W.
  assign rr_next = (grant_idx == LAST_CH) ?
                   '0 : grant_idx + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_hit   <= 1'b0;
      rr_ptr    <= '0;
    end else if (load) begin
      unique case (1'b1)
        xfer: begin
          out_valid <= 1'b1;
          out_data  <= grant_data;
          out_ch    <= grant_idx;
          out_hit   <= 1'b1;
          if (mode) rr_ptr <= rr_next;
        end
        dflt_beat: begin
          out_valid <= 1'b1;
          out_data  <= DEFAULT_VAL;
          out_ch    <= sel;
          out_hit   <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_key_stream.sv
// tb_mux_key_stream: scoreboard bench for mux_key_stream.
// 4-channel random/directed run plus a 3-channel default-key instance.
module tb_mux_key_stream;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, mode, out_ready;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_hit, out_valid;

  logic        rst3_n, mode3, out_ready3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_hit3, out_valid3;

  mux_key_stream dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch),
    .out_hit(out_hit), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux_key_stream #(
    .NR_CH(3), .SEL_W(2), .DATA_W(8),
    .DEFAULT_VAL(8'h5A)
  ) dut3 (
    .clk(clk), .rst_n(rst3_n), .mode(mode3),
    .sel(sel3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_ch(out_ch3),
    .out_hit(out_hit3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] ch;
    logic       hit;
  } beat_t;

  beat_t      q[$];
  int         checks = 0;
  int         errors = 0;
  int         m_ptr  = 0;
  bit         m_valid = 0;
  logic [3:0] acc = '0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h",
               nm, act, exp);
    end
  endtask

  // Monitor: the head of the queue is the beat
  // the DUT must be presenting; it is popped
  // once the consumer takes it.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected ch=%0d",
                   out_ch);
        end else begin
          chk("out_data", 32'(out_data),
              32'(q[0].d));
          chk("out_ch", 32'(out_ch),
              32'(q[0].ch));
          chk("out_hit", 32'(out_hit),
              32'(q[0].hit));
          if (out_ready) void'(q.pop_front());
        end
      end else begin
        chk("beat_missing", 32'(q.size()), 0);
      end
    end
  end

  // One clock of the reference model. Inputs are
  // already driven; check in_ready, then apply
  // the edge to the model.
  task automatic cycle();
    bit         ld, found, dflt;
    int         g, c;
    logic [3:0] exp_rdy;
    #3;
    ld    = !m_valid || out_ready;
    found = 0;
    dflt  = 0;
    g     = 0;
    if (!mode) begin
      if (int'(sel) >= NCH) dflt = 1;
      else if (in_valid[sel]) begin
        found = 1;
        g     = int'(sel);
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        c = (m_ptr + k) % NCH;
        if (!found && in_valid[c]) begin
          found = 1;
          g     = c;
        end
      end
    end
    exp_rdy = (rst_n && ld && found) ?
              4'(1 << g) : 4'b0;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    acc = exp_rdy;
    if (!rst_n) begin
      m_valid = 0;
      m_ptr   = 0;
      q.delete();
    end else if (ld) begin
      if (found) begin
        q.push_back('{in_data[g*8 +: 8],
                      2'(g), 1'b1});
        m_valid = 1;
        if (mode) m_ptr = (g + 1) % NCH;
      end else if (dflt) begin
        q.push_back('{8'h00, sel, 1'b0});
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic step3();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 0;
    mode      = 0;
    sel       = 0;
    in_valid  = 4'hF;
    in_data   = $urandom;
    out_ready = 1;
    rst3_n    = 0;
    mode3     = 0;
    sel3      = 0;
    in_valid3 = '0;
    in_data3  = '0;
    out_ready3 = 1;

    cycle();
    cycle();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ch", 32'(out_ch), 0);
    chk("rst_hit", 32'(out_hit), 0);

    rst_n = 1;
    mode  = 1;
    for (int i = 0; i < 4; i++) cycle();
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) cycle();

    mode     = 0;
    sel      = 2;
    in_valid = 4'b0100;
    in_data[23:16] = 8'hA5;
    cycle();

    mode      = 1;
    in_valid  = 4'hF;
    out_ready = 0;
    for (int i = 0; i < 3; i++) cycle();
    out_ready = 1;
    cycle();
    cycle();

    in_valid = 4'b0010;
    cycle();
    out_ready = 0;
    in_valid  = 4'hF;
    cycle();
    rst_n = 0;
    cycle();
    rst_n     = 1;
    out_ready = 1;
    cycle();
    cycle();

    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!(in_valid[c] && !acc[c])) begin
          in_valid[c] = ($urandom % 3) != 0;
          in_data[c*8 +: 8] = 8'($urandom);
        end
      end
      if ($urandom % 8 == 0) mode = ~mode;
      sel       = 2'($urandom);
      out_ready = ($urandom % 4) != 0;
      rst_n     = ($urandom % 64) != 0;
      cycle();
    end

    rst_n     = 1;
    in_valid  = '0;
    out_ready = 1;
    mode      = 0;
    cycle();
    cycle();

    step3();
    rst3_n    = 1;
    sel3      = 3;
    in_valid3 = 3'b111;
    in_data3  = {8'h33, 8'h3C, 8'h11};
    #3 chk("k3_rdy_dflt", 32'(in_ready3), 0);
    step3();
    chk("k3_dflt_v", 32'(out_valid3), 1);
    chk("k3_dflt_d", 32'(out_data3), 32'h5A);
    chk("k3_dflt_ch", 32'(out_ch3), 3);
    chk("k3_dflt_hit", 32'(out_hit3), 0);
    #3 chk("k3_rdy_dflt2", 32'(in_ready3), 0);
    step3();
    chk("k3_dflt2_d", 32'(out_data3), 32'h5A);

    sel3 = 1;
    #3 chk("k3_rdy_key", 32'(in_ready3), 3'b010);
    step3();
    chk("k3_key_d", 32'(out_data3), 32'h3C);
    chk("k3_key_ch", 32'(out_ch3), 1);
    chk("k3_key_hit", 32'(out_hit3), 1);

    mode3     = 1;
    in_valid3 = 3'b100;
    #3 chk("k3_rdy_rr2", 32'(in_ready3), 3'b100);
    step3();
    chk("k3_rr2_ch", 32'(out_ch3), 2);
    chk("k3_rr2_d", 32'(out_data3), 32'h33);
    in_valid3 = 3'b101;
    #3 chk("k3_rdy_wrap", 32'(in_ready3), 3'b001);
    step3();
    chk("k3_wrap_ch", 32'(out_ch3), 0);
    chk("k3_wrap_d", 32'(out_data3), 32'h11);

    out_ready3 = 0;
    mode3      = 0;
    sel3       = 3;
    #3 chk("k3_rdy_stall", 32'(in_ready3), 0);
    step3();
    chk("k3_hold_ch", 32'(out_ch3), 0);
    chk("k3_hold_hit", 32'(out_hit3), 1);
    chk("k3_hold_d", 32'(out_data3), 32'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
